// File: rtl/vpu_pkg.sv
// Shared definitions for the multi-channel video DMA: register offsets,
// CTRL bit positions and the transfer FSM encoding.
package vpu_pkg;

  localparam logic [2:0] REG_SRC_H  = 3'd0;
  localparam logic [2:0] REG_SRC_L  = 3'd1;
  localparam logic [2:0] REG_STEP   = 3'd2;
  localparam logic [2:0] REG_LEN    = 3'd3;
  localparam logic [2:0] REG_DST    = 3'd4;
  localparam logic [2:0] REG_CTRL   = 3'd5;
  localparam logic [2:0] REG_REMAIN = 3'd6;

  localparam int CTRL_DONE  = 7;
  localparam int CTRL_IEN   = 6;
  localparam int CTRL_BUSY  = 1;
  localparam int CTRL_START = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_CAP
  } dma_state_t;

endpackage

// File: rtl/vpu_dma_rr_arb.sv
// Combinational round-robin arbiter: grants the first requesting channel
// strictly after the last served one, the last served one itself ranking lowest.
module vpu_dma_rr_arb #(
  parameter int CHANNELS = 2,
  parameter int IDX_W    = 1
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [IDX_W-1:0]    last,
  output logic [IDX_W-1:0]    grant,
  output logic                valid
);

  // Scan from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int off = CHANNELS; off >= 1; off--) begin
      if (req[(int'(last) + off) % CHANNELS]) begin
        grant = IDX_W'((int'(last) + off) % CHANNELS);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vpu_dma_mc.sv
// Multi-channel DMA: copies bytes from external memory into a cache write
// port, channels served round-robin at burst boundaries over hold/hlda.
module vpu_dma_mc
  import vpu_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int ADDR_W      = 16,
  parameter int LEN_W       = 8,
  parameter int CACHE_AW    = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [$clog2(CHANNELS)+2:0] AD,
  input  logic [7:0]                  DI,
  output logic [7:0]                  DO,
  input  logic                        rw,
  input  logic                        cs,
  output logic                        irq,
  output logic                        hold,
  input  logic                        hlda,
  output logic [ADDR_W-1:0]           VADDR,
  input  logic [7:0]                  VDATA,
  output logic                        cache_we,
  output logic [CACHE_AW-1:0]         cache_addr,
  output logic [7:0]                  cache_wdata
);

  localparam int         IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [7:0] DST_MASK = 8'((1 << CACHE_AW) - 1);

  logic [ADDR_W-1:0] src_reg    [CHANNELS];
  logic [7:0]        step_reg   [CHANNELS];
  logic [LEN_W-1:0]  len_reg    [CHANNELS];
  logic [7:0]        dst_reg    [CHANNELS];
  logic [LEN_W-1:0]  remain_reg [CHANNELS];
  logic              done_reg   [CHANNELS];
  logic              ien_reg    [CHANNELS];
  logic              busy_reg   [CHANNELS];
  logic [CHANNELS-1:0] busy_vec, irq_vec;

  dma_state_t        state_reg, state_next;
  logic [IDX_W-1:0]  cur_reg, cur_next, last_reg, last_next, grant;
  logic [2:0]        wait_reg, wait_next;
  logic              grant_valid, cap_last;
  logic [IDX_W-1:0]  reg_ch;
  logic              ch_ok, reg_wr;
  logic [7:0]        rd_data;
  logic [15:0]       src16;

  generate
    if (CHANNELS > 1) begin : g_sel
      assign reg_ch = AD[IDX_W+2:3];
    end else begin : g_nosel
      assign reg_ch = '0;
    end
  endgenerate

  assign ch_ok    = (32'(reg_ch) < CHANNELS);
  assign reg_wr   = cs & ~rw;
  assign cap_last = (state_reg == ST_CAP) && (remain_reg[cur_reg] == LEN_W'(1));

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      wire wr_hit  = reg_wr && ch_ok && (reg_ch == IDX_W'(gi));
      wire cap_hit = (state_reg == ST_CAP) && (cur_reg == IDX_W'(gi));
      wire [ADDR_W-1:0] step_ext = {{(ADDR_W-8){step_reg[gi][7]}}, step_reg[gi]};

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          src_reg[gi]    <= '0;
          step_reg[gi]   <= 8'd1;
          len_reg[gi]    <= '0;
          dst_reg[gi]    <= '0;
          remain_reg[gi] <= '0;
          done_reg[gi]   <= 1'b0;
          ien_reg[gi]    <= 1'b0;
          busy_reg[gi]   <= 1'b0;
        end else begin
          // Transfer parameters are frozen while the channel is armed.
          if (wr_hit && !busy_reg[gi]) begin
            case (AD[2:0])
              REG_SRC_H: src_reg[gi]  <= ADDR_W'({DI, src_reg[gi][7:0]});
              REG_SRC_L: src_reg[gi]  <= {src_reg[gi][ADDR_W-1:8], DI};
              REG_STEP:  step_reg[gi] <= DI;
              REG_LEN:   len_reg[gi]  <= LEN_W'(DI);
              REG_DST:   dst_reg[gi]  <= DI;
              default: ;
            endcase
          end
          if (wr_hit && AD[2:0] == REG_CTRL) begin
            ien_reg[gi] <= DI[CTRL_IEN];
            if (DI[CTRL_DONE]) done_reg[gi] <= 1'b0;
            if (DI[CTRL_START] && !busy_reg[gi]) begin
              if (len_reg[gi] == '0) begin
                done_reg[gi] <= 1'b1;
              end else begin
                busy_reg[gi]   <= 1'b1;
                remain_reg[gi] <= len_reg[gi];
              end
            end
          end
          // Placed last so a completing transfer beats a same-cycle DONE clear.
          if (cap_hit) begin
            src_reg[gi]    <= src_reg[gi] + step_ext;
            dst_reg[gi]    <= (dst_reg[gi] & ~DST_MASK) | ((dst_reg[gi] + 8'd1) & DST_MASK);
            remain_reg[gi] <= remain_reg[gi] - LEN_W'(1);
            if (remain_reg[gi] == LEN_W'(1)) begin
              busy_reg[gi] <= 1'b0;
              done_reg[gi] <= 1'b1;
            end
          end
        end
      end

      assign busy_vec[gi] = busy_reg[gi];
      assign irq_vec[gi]  = done_reg[gi] & ien_reg[gi];
    end
  endgenerate

  vpu_dma_rr_arb #(
    .CHANNELS(CHANNELS),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req  (busy_vec),
    .last (last_reg),
    .grant(grant),
    .valid(grant_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cur_reg   <= '0;
      last_reg  <= IDX_W'(CHANNELS - 1);
      wait_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cur_reg   <= cur_next;
      last_reg  <= last_next;
      wait_reg  <= wait_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cur_next   = cur_reg;
    last_next  = last_reg;
    wait_next  = wait_reg;
    case (state_reg)
      ST_IDLE: begin
        if (grant_valid) begin
          cur_next   = grant;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (hlda) begin
          state_next = ST_WAIT;
          wait_next  = 3'(WAIT_CYCLES);
        end
      end
      ST_WAIT: begin
        if (!hlda) begin
          state_next = ST_REQ;
        end else if (wait_reg <= 3'd1) begin
          state_next = ST_CAP;
          wait_next  = 3'd0;
        end else begin
          wait_next = wait_reg - 3'd1;
        end
      end
      ST_CAP: begin
        if (cap_last) begin
          last_next  = cur_reg;
          state_next = ST_IDLE;
        end else begin
          state_next = ST_WAIT;
          wait_next  = 3'(WAIT_CYCLES);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign hold        = (state_reg != ST_IDLE);
  assign VADDR       = (state_reg == ST_WAIT || state_reg == ST_CAP) ? src_reg[cur_reg] : '0;
  assign cache_we    = (state_reg == ST_CAP);
  assign cache_addr  = cache_we ? dst_reg[cur_reg][CACHE_AW-1:0] : '0;
  assign cache_wdata = cache_we ? VDATA : 8'd0;
  assign irq         = |irq_vec;

  always_comb begin
    rd_data = 8'd0;
    src16   = 16'd0;
    if (ch_ok) begin
      src16 = 16'(src_reg[reg_ch]);
      case (AD[2:0])
        REG_SRC_H:  rd_data = src16[15:8];
        REG_SRC_L:  rd_data = src16[7:0];
        REG_STEP:   rd_data = step_reg[reg_ch];
        REG_LEN:    rd_data = 8'(len_reg[reg_ch]);
        REG_DST:    rd_data = dst_reg[reg_ch];
        REG_CTRL: begin
          rd_data[CTRL_DONE] = done_reg[reg_ch];
          rd_data[CTRL_IEN]  = ien_reg[reg_ch];
          rd_data[CTRL_BUSY] = busy_reg[reg_ch];
        end
        REG_REMAIN: rd_data = 8'(remain_reg[reg_ch]);
        default:    rd_data = 8'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) DO <= 8'd0;
    else if (cs && rw) DO <= rd_data;
  end

endmodule
